// File: rtl/stack_mem_unit_if.sv
// ---------------------------------------------------------------------------
// stack_mem_unit_if
//   Request/acknowledge data-memory bus between the stack/memory unit and the
//   data memory. The requester asserts dm_req and keeps dm_we, dm_addr and
//   dm_wdata stable until dm_ack. dm_rdata is valid in the dm_ack cycle.
//
//   Signals:
//     dm_req   requester -> memory  request, held until dm_ack
//     dm_we    requester -> memory  1 = write, 0 = read
//     dm_addr  requester -> memory  word address (ADDR_W)
//     dm_wdata requester -> memory  write data (DATA_W)
//     dm_ack   memory -> requester  completion, read data valid same cycle
//     dm_rdata memory -> requester  read data (DATA_W)
//
//   Modports: master = requester (the stack unit), slave = memory.
// ---------------------------------------------------------------------------
interface stack_mem_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output dm_req,
    output dm_we,
    output dm_addr,
    output dm_wdata,
    input  dm_ack,
    input  dm_rdata
  );

  modport slave (
    input  dm_req,
    input  dm_we,
    input  dm_addr,
    input  dm_wdata,
    output dm_ack,
    output dm_rdata
  );

endinterface : stack_mem_unit_if

// File: rtl/stack_mem_unit.sv
// ---------------------------------------------------------------------------
// stack_mem_unit
//   Memory-stage responder. Executes the decoder's memory/stack controls
//   (load, store, push, pop, call, return), owns the stack pointer and runs at
//   most one data-memory transaction per accepted op. op_ready is low while an
//   op is in flight so the pipeline stalls.
//
//   The stack is full-descending: sp points at the last pushed word, SP_TOP is
//   the empty value and SP_BOT the full value.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     op_valid / op_ready      op handshake from decode
//     mem_rd, mem_wr           decoded load / store controls
//     mem_addr_sel             1 = SP-relative access, 0 = use addr_in
//     sp_sel                   00 hold, 01 push, 10 pop, 11 reserved (= hold)
//     call, returni            push pc_ret / pop return address
//     addr_in, wr_data, pc_ret operands, sampled only at accept
//     done                     one-cycle completion pulse
//     rd_data                  load/pop result, valid with done
//     ret_valid                with done for a successful returni
//     err_ovf, err_unf         with done on stack overflow / underflow
//     sp                       current stack pointer
//     dm                       data-memory bus (master side)
// ---------------------------------------------------------------------------
module stack_mem_unit #(
  parameter int                 DATA_W = 32,
  parameter int                 ADDR_W = 16,
  parameter logic [ADDR_W-1:0]  SP_TOP = 16'hFFFF,
  parameter logic [ADDR_W-1:0]  SP_BOT = 16'hFF00
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              op_valid,
  output logic              op_ready,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              mem_addr_sel,
  input  logic [1:0]        sp_sel,
  input  logic              call,
  input  logic              returni,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] pc_ret,

  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              ret_valid,
  output logic              err_ovf,
  output logic              err_unf,
  output logic [ADDR_W-1:0] sp,

  stack_mem_unit_if.master  dm
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_STORE,
    OP_LOAD
  } op_kind_t;

  state_t            state;
  state_t            state_nxt;

  // Decoded view of the op currently on the inputs.
  op_kind_t          dec_kind;
  logic [DATA_W-1:0] dec_data;
  logic              dec_ret;
  logic              dec_ovf;
  logic              dec_unf;
  logic              accept;

  // Latched copy of the accepted op.
  op_kind_t          kind_q;
  logic              ret_q;
  logic              ovf_q;
  logic              unf_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // -------------------------------------------------------------------------
  // Decode, highest priority first. call and returni override any plain
  // stack or memory controls that arrive with them. Reserved sp_sel=11 never
  // matches the stack rules, so it falls through to store/load on addr_in.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first;
    // any path that skips an assignment would otherwise infer a latch.
    dec_kind = OP_NONE;
    dec_data = wr_data;
    dec_ret  = 1'b0;
    if (call) begin
      dec_kind = OP_PUSH;
      dec_data = pc_ret;
    end else if (returni) begin
      dec_kind = OP_POP;
      dec_ret  = 1'b1;
    end else if (mem_addr_sel && (sp_sel == 2'b01)) begin
      dec_kind = OP_PUSH;
    end else if (mem_addr_sel && (sp_sel == 2'b10) && mem_rd) begin
      dec_kind = OP_POP;
    end else if (mem_wr) begin
      dec_kind = OP_STORE;
    end else if (mem_rd) begin
      dec_kind = OP_LOAD;
    end
  end

  assign accept  = op_valid && (state == S_IDLE);
  assign dec_ovf = (dec_kind == OP_PUSH) && (sp == SP_BOT);
  assign dec_unf = (dec_kind == OP_POP)  && (sp == SP_TOP);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state. A no-action op is consumed in IDLE without leaving it.
  // Bounds errors skip the memory access and complete on the next cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept && (dec_kind != OP_NONE)) begin
          state_nxt = (dec_ovf || dec_unf) ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (dm.dm_ack) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs decoded from the registered state. dm_req comes straight from the
  // state register, so an asynchronous reset drops it immediately.
  // -------------------------------------------------------------------------
  assign op_ready    = (state == S_IDLE);
  assign done        = (state == S_RESP);
  assign ret_valid   = (state == S_RESP) && ret_q && !unf_q;
  assign err_ovf     = (state == S_RESP) && ovf_q;
  assign err_unf     = (state == S_RESP) && unf_q;

  assign dm.dm_req   = (state == S_REQ);
  assign dm.dm_we    = we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_wdata = wdata_q;

  // -------------------------------------------------------------------------
  // Datapath. The request fields are captured at accept and stay stable for
  // the whole REQ phase. SP moves only in the dm_ack cycle, never at accept.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp      <= SP_TOP;
      rd_data <= '0;
      kind_q  <= OP_NONE;
      ret_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (accept && (dec_kind != OP_NONE)) begin
        kind_q <= dec_kind;
        ret_q  <= dec_ret;
        ovf_q  <= dec_ovf;
        unf_q  <= dec_unf;
        if (dec_unf) begin
          rd_data <= '0;
        end
        if (!(dec_ovf || dec_unf)) begin
          unique case (dec_kind)
            OP_PUSH: begin
              addr_q  <= sp - ADDR_W'(1);
              we_q    <= 1'b1;
              wdata_q <= dec_data;
            end
            OP_POP: begin
              addr_q  <= sp;
              we_q    <= 1'b0;
            end
            OP_STORE: begin
              addr_q  <= addr_in;
              we_q    <= 1'b1;
              wdata_q <= wr_data;
            end
            OP_LOAD: begin
              addr_q  <= addr_in;
              we_q    <= 1'b0;
            end
            default: begin
            end
          endcase
        end
      end

      // dm_ack is only meaningful while a request is outstanding.
      if ((state == S_REQ) && dm.dm_ack) begin
        if (!we_q) begin
          rd_data <= dm.dm_rdata;
        end
        if (kind_q == OP_PUSH) begin
          sp <= sp - ADDR_W'(1);
        end else if (kind_q == OP_POP) begin
          sp <= sp + ADDR_W'(1);
        end
      end
    end
  end

endmodule : stack_mem_unit

// File: tb/tb_stack_mem_unit.sv
// ---------------------------------------------------------------------------
// tb_stack_mem_unit
//   Directed scoreboard bench for stack_mem_unit. Each issued op pushes its
//   expected memory request and its expected completion into queues; a memory
//   responder and a completion monitor pop and compare independently.
// ---------------------------------------------------------------------------
module tb_stack_mem_unit;

  localparam int DW = 32;
  localparam int AW = 16;

  typedef struct {
    logic          call;
    logic          ret;
    logic          mas;
    logic [1:0]    ss;
    logic          rd;
    logic          wr;
    logic [AW-1:0] ai;
    logic [DW-1:0] wd;
    logic [DW-1:0] pc;
  } op_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } req_t;

  typedef struct {
    logic [DW-1:0] rd;
    logic          ret;
    logic          ovf;
    logic          unf;
    logic [AW-1:0] sp;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          op_valid, op_ready;
  logic          mem_rd, mem_wr, mem_addr_sel, call, returni;
  logic [1:0]    sp_sel;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] wr_data, pc_ret;
  logic          done, ret_valid, err_ovf, err_unf;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] sp;

  stack_mem_unit_if #(.DATA_W(DW), .ADDR_W(AW)) dm ();

  stack_mem_unit dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_addr_sel (mem_addr_sel),
    .sp_sel       (sp_sel),
    .call         (call),
    .returni      (returni),
    .addr_in      (addr_in),
    .wr_data      (wr_data),
    .pc_ret       (pc_ret),
    .done         (done),
    .rd_data      (rd_data),
    .ret_valid    (ret_valid),
    .err_ovf      (err_ovf),
    .err_unf      (err_unf),
    .sp           (sp),
    .dm           (dm)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int ack_delay = 0;
  int req_cnt = 0;
  int last_req_len = 0;
  bit ack_en = 1'b1;
  bit force_ack = 1'b0;

  req_t req_q[$];
  rsp_t exp_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    check(nm, {31'b0, act}, {31'b0, exp});
  endtask

  function automatic op_t mk_op(logic c, logic r, logic mas, logic [1:0] ss, logic rd,
                                logic wr, logic [AW-1:0] ai, logic [DW-1:0] wd,
                                logic [DW-1:0] pc);
    op_t o;
    o.call = c;  o.ret = r;  o.mas = mas; o.ss = ss; o.rd = rd; o.wr = wr;
    o.ai = ai;   o.wd = wd;  o.pc = pc;
    return o;
  endfunction

  function automatic req_t mk_req(logic we, logic [AW-1:0] a, logic [DW-1:0] wd);
    req_t q;
    q.we = we; q.addr = a; q.wd = wd;
    return q;
  endfunction

  function automatic rsp_t mk_rsp(logic [DW-1:0] rd, logic ret, logic ovf, logic unf,
                                  logic [AW-1:0] s);
    rsp_t p;
    p.rd = rd; p.ret = ret; p.ovf = ovf; p.unf = unf; p.sp = s;
    return p;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder: checks each request against the expected queue, checks
  // that the request stays stable while held, and acks after ack_delay cycles.
  initial begin
    req_t rq;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wd;
    logic          h_we;
    dm.dm_ack   = 1'b0;
    dm.dm_rdata = '0;
    forever begin
      @(negedge clk);
      if (dm.dm_req && !rst) begin
        if (req_cnt == 0) begin
          check1("dm_req expected", req_q.size() != 0, 1'b1);
          if (req_q.size() != 0) begin
            rq = req_q.pop_front();
            check1("dm_we", dm.dm_we, rq.we);
            check("dm_addr", {16'h0, dm.dm_addr}, {16'h0, rq.addr});
            if (rq.we) check("dm_wdata", dm.dm_wdata, rq.wd);
          end
          h_addr = dm.dm_addr;
          h_wd   = dm.dm_wdata;
          h_we   = dm.dm_we;
        end else begin
          check1("dm_req stable", (dm.dm_addr == h_addr) && (dm.dm_wdata == h_wd)
                 && (dm.dm_we == h_we), 1'b1);
        end
        req_cnt++;
        last_req_len = req_cnt;
        if (ack_en && (req_cnt > ack_delay)) begin
          dm.dm_ack = 1'b1;
          if (dm.dm_we) begin
            mem[dm.dm_addr] = dm.dm_wdata;
            dm.dm_rdata = $urandom;
          end else begin
            dm.dm_rdata = mem.exists(dm.dm_addr) ? mem[dm.dm_addr] : 32'h0;
          end
        end else begin
          dm.dm_ack   = 1'b0;
          dm.dm_rdata = $urandom;
        end
      end else begin
        req_cnt     = 0;
        dm.dm_ack   = force_ack;
        dm.dm_rdata = $urandom;
      end
    end
  end

  // Completion monitor.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) begin
          check1("done expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rd_data", rd_data, e.rd);
            check1("ret_valid", ret_valid, e.ret);
            check1("err_ovf", err_ovf, e.ovf);
            check1("err_unf", err_unf, e.unf);
            check("sp", {16'h0, sp}, {16'h0, e.sp});
          end
          done_cnt++;
        end else begin
          check1("pulse without done", ret_valid | err_ovf | err_unf, 1'b0);
        end
      end
    end
  end

  task automatic drive(input op_t o);
    call = o.call; returni = o.ret; mem_addr_sel = o.mas; sp_sel = o.ss;
    mem_rd = o.rd; mem_wr = o.wr; addr_in = o.ai; wr_data = o.wd; pc_ret = o.pc;
  endtask

  // Issue one op; lat is the cycle count from the accept edge to the cycle in
  // which done is visible.
  task automatic issue(input string name, input op_t o, input bit has_req, input req_t rq,
                       input bit has_done, input rsp_t rs, input int dly, input int lat);
    int acc;
    int n;
    bit got;
    bit hi_seen;
    n = 0;
    @(negedge clk);
    while (!op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check1({name, " ready"}, op_ready, 1'b1);
    ack_delay = dly;
    if (has_req)  req_q.push_back(rq);
    if (has_done) exp_q.push_back(rs);
    drive(o);
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    op_valid = 1'b0;
    // Garbage after accept: the unit must ignore it.
    drive(mk_op(1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, AW'($urandom), $urandom, $urandom));
    if (has_done) begin
      got = 1'b0;
      hi_seen = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        @(negedge clk);
        if (done) got = 1'b1;
        else if (op_ready) hi_seen = 1'b1;
      end
      check1({name, " done"}, got, 1'b1);
      check({name, " latency"}, cyc - acc, lat);
      check1({name, " stall"}, hi_seen | op_ready, 1'b0);
      @(negedge clk);
      check1({name, " ready after"}, op_ready, 1'b1);
    end else begin
      n = done_cnt;
      repeat (3) @(negedge clk);
      check({name, " no done"}, done_cnt, n);
      check1({name, " ready kept"}, op_ready, 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    req_t nr;
    nr = mk_req(1'b0, 16'h0, 32'h0);
    op_valid = 1'b0;
    drive(mk_op(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0));

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset sp", {16'h0, sp}, 32'h0000FFFF);
    check1("reset dm_req", dm.dm_req, 1'b0);
    check1("reset dm_we", dm.dm_we, 1'b0);
    check("reset dm_addr", {16'h0, dm.dm_addr}, 32'h0);
    check("reset dm_wdata", dm.dm_wdata, 32'h0);
    check("reset rd_data", rd_data, 32'h0);
    check1("reset pulses", done | ret_valid | err_ovf | err_unf, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check1("idle op_ready", op_ready, 1'b1);
    check1("idle dm_req", dm.dm_req, 1'b0);

    // Push then pop, ack in first REQ cycle.
    issue("push", mk_op(0, 0, 1, 2'b01, 0, 0, 16'h1234, 32'hDEADBEEF, 32'h0),
          1, mk_req(1, 16'hFFFE, 32'hDEADBEEF), 1, mk_rsp(32'h0, 0, 0, 0, 16'hFFFE), 0, 1);
    issue("pop", mk_op(0, 0, 1, 2'b10, 1, 0, 16'h1234, 32'h0, 32'h0),
          1, mk_req(0, 16'hFFFE, 32'h0), 1, mk_rsp(32'hDEADBEEF, 0, 0, 0, 16'hFFFF), 0, 1);

    // Store with ack delayed three cycles; rd_data untouched by a write.
    issue("store", mk_op(0, 0, 0, 2'b00, 0, 1, 16'h0040, 32'h12345678, 32'h0),
          1, mk_req(1, 16'h0040, 32'h12345678), 1, mk_rsp(32'hDEADBEEF, 0, 0, 0, 16'hFFFF), 3, 4);
    check("store req length", last_req_len, 4);
    issue("load", mk_op(0, 0, 0, 2'b00, 1, 0, 16'h0040, 32'h0, 32'h0),
          1, mk_req(0, 16'h0040, 32'h0), 1, mk_rsp(32'h12345678, 0, 0, 0, 16'hFFFF), 1, 2);

    // call / returni, then call with mem_rd (call wins).
    issue("call", mk_op(1, 0, 0, 2'b00, 0, 0, 16'h0077, 32'hAAAA5555, 32'h00000100),
          1, mk_req(1, 16'hFFFE, 32'h00000100), 1, mk_rsp(32'h12345678, 0, 0, 0, 16'hFFFE), 0, 1);
    issue("returni", mk_op(0, 1, 0, 2'b00, 0, 0, 16'h0077, 32'h0, 32'h0),
          1, mk_req(0, 16'hFFFE, 32'h0), 1, mk_rsp(32'h00000100, 1, 0, 0, 16'hFFFF), 0, 1);
    issue("call+rd", mk_op(1, 0, 0, 2'b00, 1, 0, 16'h0040, 32'h0, 32'h00000200),
          1, mk_req(1, 16'hFFFE, 32'h00000200), 1, mk_rsp(32'h00000100, 0, 0, 0, 16'hFFFE), 0, 1);
    issue("pop2", mk_op(0, 0, 1, 2'b10, 1, 0, 16'h0, 32'h0, 32'h0),
          1, mk_req(0, 16'hFFFE, 32'h0), 1, mk_rsp(32'h00000200, 0, 0, 0, 16'hFFFF), 2, 3);

    // Reserved sp_sel falls through to a store at addr_in.
    issue("sp_sel11", mk_op(0, 0, 1, 2'b11, 0, 1, 16'h0050, 32'h0BADF00D, 32'h0),
          1, mk_req(1, 16'h0050, 32'h0BADF00D), 1, mk_rsp(32'h00000200, 0, 0, 0, 16'hFFFF), 0, 1);
    issue("noop", mk_op(0, 0, 0, 2'b10, 0, 0, 16'h0, 32'h0, 32'h0),
          0, nr, 0, mk_rsp(32'h0, 0, 0, 0, 16'hFFFF), 0, 0);

    // Underflow on empty stack.
    issue("pop empty", mk_op(0, 0, 1, 2'b10, 1, 0, 16'h0, 32'h0, 32'h0),
          0, nr, 1, mk_rsp(32'h0, 0, 0, 1, 16'hFFFF), 0, 0);
    issue("ret empty", mk_op(0, 1, 0, 2'b00, 0, 0, 16'h0, 32'h0, 32'h0),
          0, nr, 1, mk_rsp(32'h0, 0, 0, 1, 16'hFFFF), 0, 0);

    // Fill to SP_BOT, then overflow.
    for (int i = 0; i < 255; i++) begin
      issue("fill", mk_op(0, 0, 1, 2'b01, 0, 0, 16'h0, 32'h10000000 + i, 32'h0),
            1, mk_req(1, 16'(16'hFFFF - (i + 1)), 32'h10000000 + i),
            1, mk_rsp(32'h0, 0, 0, 0, 16'(16'hFFFF - (i + 1))), 0, 1);
    end
    check("full sp", {16'h0, sp}, 32'h0000FF00);
    issue("push full", mk_op(0, 0, 1, 2'b01, 0, 0, 16'h0, 32'hFFFFFFFF, 32'h0),
          0, nr, 1, mk_rsp(32'h0, 0, 1, 0, 16'hFF00), 0, 0);
    issue("call full", mk_op(1, 0, 0, 2'b00, 0, 0, 16'h0, 32'h0, 32'h00000300),
          0, nr, 1, mk_rsp(32'h0, 0, 1, 0, 16'hFF00), 0, 0);
    issue("pop top", mk_op(0, 0, 1, 2'b10, 1, 0, 16'h0, 32'h0, 32'h0),
          1, mk_req(0, 16'hFF00, 32'h0), 1, mk_rsp(32'h100000FE, 0, 0, 0, 16'hFF01), 0, 1);

    // Reset while a push waits for ack.
    ack_en = 1'b0;
    req_q.push_back(mk_req(1, 16'hFF00, 32'hCAFEF00D));
    @(negedge clk);
    drive(mk_op(0, 0, 1, 2'b01, 0, 0, 16'h0, 32'hCAFEF00D, 32'h0));
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    check1("abort req held", dm.dm_req, 1'b1);
    n = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    check1("abort dm_req", dm.dm_req, 1'b0);
    check("abort sp", {16'h0, sp}, 32'h0000FFFF);
    check1("abort done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1;
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("late ack sp", {16'h0, sp}, 32'h0000FFFF);
    check("late ack no done", done_cnt, n);
    check1("late ack dm_req", dm.dm_req, 1'b0);
    check1("late ack ready", op_ready, 1'b1);

    // Recovery after reset.
    issue("push rec", mk_op(0, 0, 1, 2'b01, 0, 0, 16'h0, 32'h00000055, 32'h0),
          1, mk_req(1, 16'hFFFE, 32'h00000055), 1, mk_rsp(32'h0, 0, 0, 0, 16'hFFFE), 0, 1);
    issue("pop rec", mk_op(0, 0, 1, 2'b10, 1, 0, 16'h0, 32'h0, 32'h0),
          1, mk_req(0, 16'hFFFE, 32'h0), 1, mk_rsp(32'h00000055, 0, 0, 0, 16'hFFFF), 0, 1);

    repeat (2) @(negedge clk);
    check("req queue drained", req_q.size(), 0);
    check("rsp queue drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_stack_mem_unit

// File: doc/stack_mem_unit.md
Name: stack_mem_unit

Overview:
- Memory-stage responder that executes the decoder's memory and stack control signals.
- Decoded controls: mem_rd, mem_wr, mem_addr_sel, sp_sel, call, returni.
- Owns the stack pointer (SP) and runs one data-memory transaction per accepted op over a req/ack handshake.
- Drives op_ready low while busy so the pipeline stalls.

Parameters:
- DATA_W, 32, data and PC width.
- ADDR_W, 16, data-memory word-address width.
- SP_TOP, 16'hFFFF, SP reset value; empty-stack pointer.
- SP_BOT, 16'hFF00, lowest legal SP; stack is full when SP==SP_BOT.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- op_valid  in  1  decode-stage op present.
- op_ready  out  1  high when unit can accept an op.
- mem_rd  in  1  read request (decoder control).
- mem_wr  in  1  write request (decoder control).
- mem_addr_sel  in  1  1 = SP-relative address, 0 = addr_in.
- sp_sel  in  2  00 hold, 01 push, 10 pop, 11 reserved (treated as 00).
- call  in  1  push pc_ret.
- returni  in  1  pop return address.
- addr_in  in  ADDR_W  computed address for load/store.
- wr_data  in  DATA_W  store/push data.
- pc_ret  in  DATA_W  return PC for call.
- done  out  1  one-cycle completion pulse.
- rd_data  out  DATA_W  load/pop result, valid with done.
- ret_valid  out  1  pulses with done for returni; rd_data holds return PC.
- err_ovf  out  1  pulses with done on push/call when full.
- err_unf  out  1  pulses with done on pop/returni when empty.
- sp  out  ADDR_W  current stack pointer.
- dm_req  out  1  memory request, held until dm_ack.
- dm_we  out  1  write enable for the request.
- dm_addr  out  ADDR_W  request address.
- dm_wdata  out  DATA_W  write data.
- dm_ack  in  1  memory completion; read data valid same cycle.
- dm_rdata  in  DATA_W  read data.

Behaviour:
- Reset (async, rst=1):
  - State IDLE; sp=SP_TOP.
  - dm_req, dm_we, done, ret_valid, err_ovf and err_unf are 0.
  - rd_data, dm_addr and dm_wdata are 0; op_ready=1 after reset release.
  - Reset mid-transaction aborts: dm_req drops immediately, no done, SP restored to SP_TOP.
- Accept: op_valid && op_ready at edge T. Controls are latched; inputs are ignored afterwards.
- Decode priority (highest first):
  1. call: push pc_ret.
  2. returni: pop.
  3. mem_addr_sel && sp_sel==01: push wr_data.
  4. mem_addr_sel && sp_sel==10 && mem_rd: pop.
  5. mem_wr: store wr_data to addr_in.
  6. mem_rd: load from addr_in.
  7. Otherwise: no action. The op is consumed, no done, op_ready stays 1.
- Stack is full-descending; SP points at the last pushed word.
  - Push: dm_addr=SP-1, dm_we=1; SP becomes SP-1.
  - Pop: dm_addr=SP, dm_we=0; SP becomes SP+1.
  - SP changes only on the dm_ack cycle, never speculatively.
- State machine: IDLE -> REQ -> RESP -> IDLE.
  - IDLE: op_ready=1. A valid memory op goes to REQ. An error op goes to RESP with no memory access.
  - REQ: dm_req=1 starting cycle T+1, with dm_we/dm_addr/dm_wdata stable. Stay in REQ while dm_ack=0. On dm_ack: capture dm_rdata (reads), update SP, go to RESP.
  - RESP: done=1 for one cycle, with ret_valid/err_* as applicable. op_ready=0; next state IDLE.
  - Minimum latency with dm_ack in the first REQ cycle: accept T, req T+1, done T+2, next accept at edge T+3.
- Boundaries:
  - Push/call with SP==SP_BOT: no dm_req, SP unchanged, done+err_ovf at T+1.
  - Pop/returni with SP==SP_TOP: no dm_req, SP unchanged, rd_data=0, done+err_unf at T+1.
  - SP arithmetic is modulo 2^ADDR_W, but the bounds checks prevent wrap.
- Write ops leave rd_data at its previous value.
- dm_ack outside REQ is ignored.
- Reserved sp_sel=11 with mem_addr_sel=1 falls through to the store/load rules using addr_in.

Test Plan:
- Reset then idle -> sp=16'hFFFF, op_ready=1, dm_req=0, all pulses 0.
- Push 32'hDEADBEEF with ack at first REQ cycle -> dm_addr=16'hFFFE, dm_we=1, sp=16'hFFFE, done two cycles after accept. Then pop -> dm_addr=16'hFFFE, rd_data=32'hDEADBEEF, sp=16'hFFFF.
- Store 32'h12345678 to 16'h0040 with ack delayed 3 cycles -> dm_req held 4 cycles with stable addr/data, op_ready=0 throughout, single done pulse, sp unchanged.
- call (pc_ret=32'h00000100) then returni -> push to 16'hFFFE, then pop gives rd_data=32'h00000100 with ret_valid=1 and sp=16'hFFFF. call also asserted with mem_rd -> call wins.
- Pop/returni at reset -> no dm_req, err_unf=1 with done at T+1. 255 pushes fill SP to 16'hFF00; 256th push -> err_ovf=1, no dm_req, sp stays 16'hFF00.
- Assert rst while in REQ (ack withheld) -> dm_req=0 same cycle, sp=16'hFFFF, no done. Late dm_ack after release is ignored.
